multicycle_data_path: RTL
=========================

// Module: multicycle_data_path
// PURPOSE
//  Multicycle MIPS-subset core: datapath plus its control FSM. Executes one instruction over 3-5 states.
//  Shares one ALU with the PC incrementer and branch adder.
//  Fetches and loads/stores through one unified memory port with a req/ready handshake, so wait states are allowed.
//  Next generation of the single-cycle data_path: XLEN-parametrised, multicycle, stall-tolerant, illegal-opcode trap.
// PARAMETERS
//  XLEN      32     datapath/register width; legal values 32 or 64
//  RESET_PC  0      PC value loaded at reset
//  EN_BNE    1      1: decode bne (opcode 000101); 0: bne traps as illegal
// PORTS
//  clk        in   1     clock, rising edge
//  reset      in   1     asynchronous, active-low reset
//  mem_req    out  1     memory transaction request
//  mem_we     out  1     1 = write (sw), 0 = read
//  mem_addr   out  XLEN  byte address; word-aligned
//  mem_wdata  out  XLEN  store data (rt value)
//  mem_rdata  in   XLEN  read data; valid when mem_req & mem_ready
//  mem_ready  in   1     completes the current transaction this cycle
//  pc         out  XLEN  current PC register
//  instr_done out  1     1-cycle pulse on the retiring state of each instruction
//  illegal    out  1     sticky; set on an undecodable instruction
// BEHAVIOUR
//  Reset (reset=0), async:
//   - PC=RESET_PC; IR, A, B, ALUOut, MDR and all 32 GPRs = 0
//   - state=IDLE; mem_req=0, mem_we=0, instr_done=0, illegal=0
//   - reset mid-transaction aborts it immediately: mem_req drops asynchronously
//  Handshake:
//   - mem_req is high only in FETCH, MEMRD and MEMWR
//   - addr/we/wdata stay stable until the edge where mem_ready=1; the state advances only at that edge
//   - mem_ready while mem_req=0 is ignored
//  Instruction word = mem_rdata[31:0], latched into IR at the FETCH handshake
//  FSM (mc_control_fsm):
//   - IDLE -> FETCH unconditionally
//   - FETCH: addr=PC; on ready: IR<=rdata, PC<=PC+4 -> DECODE
//   - DECODE: A<=rs, B<=rt, ALUOut<=PC+(sext(imm)<<2)
//     lw/sw -> MEMADR; R-type -> EXEC; addi -> ADDIEX; beq/bne -> BRANCH; j -> JUMP; other -> TRAP
//   - MEMADR: ALUOut<=A+sext(imm) -> MEMRD (lw) | MEMWR (sw)
//   - MEMRD: on ready MDR<=rdata -> MEMWB
//   - MEMWB: rt<=MDR, done -> FETCH
//   - MEMWR: on ready, done -> FETCH
//   - EXEC: ALUOut<=A op B -> ALUWB
//   - ALUWB: rd<=ALUOut, done -> FETCH
//   - ADDIEX: ALUOut<=A+sext(imm) -> ADDIWB
//   - ADDIWB: rt<=ALUOut, done -> FETCH
//   - BRANCH: if (A==B)^bne then PC<=ALUOut; done -> FETCH
//   - JUMP: PC<={PC[XLEN-1:28],IR[25:0],2'b00}; done -> FETCH
//   - TRAP: illegal=1, mem_req=0; stays until reset
//  R-type funct: add 100000, sub 100010, and 100100, or 100101, slt 101010 (signed); any other funct -> TRAP
//  Arithmetic: modulo 2^XLEN, no overflow exceptions; sext() extends imm[15] to XLEN
//  GPRs:
//   - r0 reads 0; writes to r0 are discarded
//   - write in a WB state happens at that state's edge
//  Latency at mem_ready=1: lw 5, sw 4, R/addi 4, beq/bne/j 3 cycles
//   - each wait cycle on FETCH, MEMRD or MEMWR adds 1
//   - instr_done asserts in the final state of each instruction
//  PC update on the FETCH edge and on the BRANCH/JUMP edge never coincide; no arbitration needed
//  Misaligned addresses: low 2 bits passed through unchanged, no trap
// STRUCTURE
//  Shared header mc_defs.vh: opcode/funct localparams, FSM state encoding (4-bit), ALU op codes
//  Sub-module mc_control_fsm: state register, decode, and all mux/enable selects
//   - the datapath keeps only registers, the GPR array and the ALU
// TESTING
//  1. reset=0 mid-FETCH with mem_ready=0 -> mem_req=0 same cycle; after release pc=RESET_PC, first req at cycle 2
//  2. addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; slt r4,r2,r1 -> r3=2, r4=1; instr_done pulses every 4 cycles
//  3. sw r3,8(r0) then lw r5,8(r0), memory ready after 2 waits
//     -> write addr 8 data 2; r5=2; lw takes 7 cycles
//  4. beq r1,r1,+2 at PC=0x10 -> next fetch 0x1C; beq not taken -> 0x14; j 0x40 -> fetch 0x100
//  5. addi r0,r0,7; add r6,r0,r0 -> r6=0 (r0 write discarded)
//  6. opcode 111111 or funct 000111 -> illegal=1 after DECODE/EXEC, mem_req stays 0, PC frozen; EN_BNE=0 with bne -> trap

Source files
------------

// File: rtl/multicycle_data_path_pkg.sv
// Shared definitions for the multicycle MIPS-subset core: opcodes, functs,
// control state encoding and the select codes the control FSM drives into the datapath.
package multicycle_data_path_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,  ST_FETCH  = 4'd1,  ST_DECODE = 4'd2,  ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,  ST_MEMWB  = 4'd5,  ST_MEMWR  = 4'd6,  ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,  ST_ADDIEX = 4'd9,  ST_ADDIWB = 4'd10, ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12, ST_TRAP   = 4'd13
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2, ALU_OR = 3'd3, ALU_SLT = 3'd4
  } alu_op_e;

  typedef enum logic {ASEL_PC = 1'b0, ASEL_A = 1'b1} alu_a_sel_e;

  typedef enum logic [1:0] {
    BSEL_B = 2'd0, BSEL_FOUR = 2'd1, BSEL_IMM = 2'd2, BSEL_IMM_SH2 = 2'd3
  } alu_b_sel_e;

  typedef enum logic [1:0] {PCSRC_ALU = 2'd0, PCSRC_ALUOUT = 2'd1, PCSRC_JUMP = 2'd2} pc_src_e;

  typedef struct packed {
    logic       ir_we;
    logic       pc_we;
    pc_src_e    pc_src;
    logic       ab_we;
    logic       aluout_we;
    logic       mdr_we;
    logic       rf_we;
    logic       rf_dst_rd;
    logic       rf_src_mdr;
    logic       addr_from_aluout;
    alu_a_sel_e alu_a_sel;
    alu_b_sel_e alu_b_sel;
    alu_op_e    alu_op;
  } ctrl_t;

  function automatic logic funct_legal(input logic [5:0] funct);
    case (funct)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e funct_to_alu_op(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_data_path_fsm.sv
// Control FSM of the multicycle core: state register, instruction decode and
// every mux select / register enable of the datapath.
module mc_control_fsm
  import multicycle_data_path_pkg::*;
#(
  parameter int EN_BNE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       a_eq_b_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       instr_done_o,
  output logic       illegal_o
);

  state_e state_q, state_d;

  // State register; async reset drops mem_req at once since it decodes from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls.
  always_comb begin
    state_d      = state_q;
    ctrl_o       = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    instr_done_o = 1'b0;
    illegal_o    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_req_o        = 1'b1;
        ctrl_o.alu_b_sel = BSEL_FOUR;
        if (mem_ready_i) begin
          ctrl_o.ir_we = 1'b1;
          ctrl_o.pc_we = 1'b1;
          state_d      = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        ctrl_o.ab_we     = 1'b1;
        ctrl_o.aluout_we = 1'b1;
        ctrl_o.alu_b_sel = BSEL_IMM_SH2;
        case (opcode_i)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = funct_legal(funct_i) ? ST_EXEC : ST_TRAP;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_BNE:       state_d = (EN_BNE != 0) ? ST_BRANCH : ST_TRAP;
          OP_J:         state_d = ST_JUMP;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MEMADR, ST_ADDIEX: begin
        ctrl_o.aluout_we = 1'b1;
        ctrl_o.alu_a_sel = ASEL_A;
        ctrl_o.alu_b_sel = BSEL_IMM;
        if (state_q == ST_ADDIEX) begin
          state_d = ST_ADDIWB;
        end else begin
          state_d = (opcode_i == OP_LW) ? ST_MEMRD : ST_MEMWR;
        end
      end
      ST_MEMRD: begin
        mem_req_o               = 1'b1;
        ctrl_o.addr_from_aluout = 1'b1;
        if (mem_ready_i) begin
          ctrl_o.mdr_we = 1'b1;
          state_d       = ST_MEMWB;
        end else begin
          state_d = ST_MEMRD;
        end
      end
      ST_MEMWB: begin
        ctrl_o.rf_we      = 1'b1;
        ctrl_o.rf_src_mdr = 1'b1;
        instr_done_o      = 1'b1;
        state_d           = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_req_o               = 1'b1;
        mem_we_o                = 1'b1;
        ctrl_o.addr_from_aluout = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_d      = ST_FETCH;
        end else begin
          state_d = ST_MEMWR;
        end
      end
      ST_EXEC: begin
        ctrl_o.aluout_we = 1'b1;
        ctrl_o.alu_a_sel = ASEL_A;
        ctrl_o.alu_b_sel = BSEL_B;
        ctrl_o.alu_op    = funct_to_alu_op(funct_i);
        state_d          = ST_ALUWB;
      end
      ST_ALUWB, ST_ADDIWB: begin
        ctrl_o.rf_we     = 1'b1;
        ctrl_o.rf_dst_rd = (state_q == ST_ALUWB);
        instr_done_o     = 1'b1;
        state_d          = ST_FETCH;
      end
      ST_BRANCH: begin
        instr_done_o  = 1'b1;
        ctrl_o.pc_src = PCSRC_ALUOUT;
        ctrl_o.pc_we  = a_eq_b_i ^ (opcode_i == OP_BNE);
        state_d       = ST_FETCH;
      end
      ST_JUMP: begin
        instr_done_o  = 1'b1;
        ctrl_o.pc_src = PCSRC_JUMP;
        ctrl_o.pc_we  = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_TRAP: begin
        illegal_o = 1'b1;
        state_d   = ST_TRAP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/multicycle_data_path.sv
// Multicycle MIPS-subset core: registers, GPR file and the single shared ALU;
// all sequencing comes from mc_control_fsm.
module multicycle_data_path
  import multicycle_data_path_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              EN_BNE   = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic [XLEN-1:0] pc,
  output logic            instr_done,
  output logic            illegal
);

  ctrl_t           ctrl;
  logic [31:0]     ir_q;
  logic [XLEN-1:0] pc_q, pc_d, a_q, b_q, aluout_q, mdr_q;
  logic [XLEN-1:0] gpr_q [32];
  logic [XLEN-1:0] imm_ext, imm_sh2, alu_a, alu_b, alu_y, wb_data;
  logic [4:0]      wb_addr;

  mc_control_fsm #(.EN_BNE(EN_BNE)) u_fsm (
    .clk          (clk),
    .rst_n        (reset),
    .opcode_i     (ir_q[31:26]),
    .funct_i      (ir_q[5:0]),
    .a_eq_b_i     (a_q == b_q),
    .mem_ready_i  (mem_ready),
    .ctrl_o       (ctrl),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .instr_done_o (instr_done),
    .illegal_o    (illegal)
  );

  assign imm_ext   = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
  assign imm_sh2   = {imm_ext[XLEN-3:0], 2'b00};
  assign mem_addr  = ctrl.addr_from_aluout ? aluout_q : pc_q;
  assign mem_wdata = b_q;
  assign pc        = pc_q;
  assign wb_addr   = ctrl.rf_dst_rd ? ir_q[15:11] : ir_q[20:16];
  assign wb_data   = ctrl.rf_src_mdr ? mdr_q : aluout_q;

  // Shared ALU: PC increment, branch target, address/immediate add and R-type ops.
  always_comb begin
    alu_a = (ctrl.alu_a_sel == ASEL_A) ? a_q : pc_q;
    case (ctrl.alu_b_sel)
      BSEL_FOUR:    alu_b = {{(XLEN-3){1'b0}}, 3'b100};
      BSEL_IMM:     alu_b = imm_ext;
      BSEL_IMM_SH2: alu_b = imm_sh2;
      default:      alu_b = b_q;
    endcase
    case (ctrl.alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  // PC source; the jump keeps the upper nibble of the already-incremented PC.
  always_comb begin
    case (ctrl.pc_src)
      PCSRC_ALUOUT: pc_d = aluout_q;
      PCSRC_JUMP:   pc_d = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
      default:      pc_d = alu_y;
    endcase
  end

  // Architectural and intermediate registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= 32'h0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
    end else begin
      if (ctrl.ir_we)     ir_q     <= mem_rdata[31:0];
      if (ctrl.pc_we)     pc_q     <= pc_d;
      if (ctrl.aluout_we) aluout_q <= alu_y;
      if (ctrl.mdr_we)    mdr_q    <= mem_rdata;
      if (ctrl.ab_we) begin
        a_q <= gpr_q[ir_q[25:21]];
        b_q <= gpr_q[ir_q[20:16]];
      end
    end
  end

  // GPR file; r0 is never written so it always reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) gpr_q[i] <= '0;
    end else if (ctrl.rf_we && (wb_addr != 5'd0)) begin
      gpr_q[wb_addr] <= wb_data;
    end
  end

endmodule
